bus_command_receiver: RTL and testbench
=======================================

Name: bus_command_receiver

Overview:
- Receiving end of the L1 and shared-bus command interfaces driven by the trace reader.
- Decodes ASCII operation codes into the numeric command set, which matches the trace-file numbering.
- Queues accepted commands in a small FIFO for the L2 cache controller.
- Keeps per-class statistics counters that are published on a print-stats request.

Parameters:
- addressSize, 32, width of address buses and queued address
- fifoDepth, 4, command queue entries (power of two, >=2)
- counterWidth, 32, width of statistics counters

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- L1BusIn  in  addressSize  L1 request address
- L1OperationBusIn  in  16  L1 op code, two ASCII chars
- l1Valid  in  1  L1 op/address valid this cycle
- l1Ready  out  1  L1 op accepted when l1Valid&&l1Ready
- sharedBusIn  in  addressSize  snooped address
- sharedOperationBusIn  in  8  snoop op code, one ASCII char
- sharedValid  in  1  snoop op valid this cycle
- sharedReady  out  1  snoop op accepted when sharedValid&&sharedReady
- cmdValid  out  1  FIFO head valid
- cmdReady  in  1  controller consumes head
- cmdType  out  4  decoded command (cmd_t)
- cmdAddress  out  addressSize  head address
- readCount  out  counterWidth  DR+IR accepted
- writeCount  out  counterWidth  DW accepted
- snoopCount  out  counterWidth  snoop ops accepted
- errorCount  out  counterWidth  illegal op codes seen
- decodeError  out  1  sticky, set on first illegal code
- statsValid  out  1  one-cycle pulse after PS accepted

Behaviour:
- Decoding on the L1 bus:
  - "DR" -> 0
  - "DW" -> 1
  - "IR" -> 2
  - "CL" -> 8
  - "PR" -> 9
  - "PS" -> stats request
- Decoding on the shared bus:
  - "I" -> 3
  - "R" -> 4
  - "W" -> 5
  - "M" -> 6
- Illegal codes:
  - Any other code with its valid asserted is illegal.
  - errorCount increments, decodeError sets, nothing is enqueued.
  - The illegal code is still handshaken: it requires the channel's ready.
- Ready rules (combinational from count and sharedValid):
  - sharedReady = (count <= fifoDepth-1).
  - l1Ready = (count <= fifoDepth-1) when sharedValid is low.
  - l1Ready = (count <= fifoDepth-2) when sharedValid is high.
  - A same-cycle pop does NOT raise ready.
- Enqueue order: when both channels are accepted in the same cycle, the snoop is written first and the L1 command second, so the snoop reaches the head earlier.
- Latency: a command accepted on edge N drives cmdValid/cmdType/cmdAddress after edge N (registered head), i.e. visible in cycle N+1.
- Dequeue: on cmdValid&&cmdReady; the head is stable while cmdValid&&!cmdReady.
- Simultaneous push and pop: count changes by (pushes - pop). This is legal when full-1 with one push and one pop.
- Pointers wrap modulo fifoDepth; count ranges 0..fifoDepth.
- Empty: cmdValid=0, and cmdType/cmdAddress hold their last values.
- CL handling: enqueued like any command. On its acceptance edge all four counters and decodeError clear. CL itself is not counted. A counter event in the same cycle is discarded (clear wins).
- PS handling: not enqueued and always accepted when l1Ready. statsValid pulses high for exactly the cycle after acceptance, and counters are frozen during that cycle.
- PR: enqueued and not counted.
- Counters saturate at all-ones and do not wrap.
- Reset values, applied asynchronously at any time including mid-transfer:
  - count=0, pointers=0
  - cmdValid=0, cmdType=0, cmdAddress=0
  - all counters 0, decodeError=0, statsValid=0
  - Queued commands are discarded.

Decomposition:
- Package bus_command_pkg:
  - cmd_t enum with DATA_READ=0, DATA_WRITE=1, INST_READ=2, SNOOP_INVALIDATE=3, SNOOP_READ=4, SNOOP_WRITE=5, SNOOP_RWITM=6, CLEAR=8, PRINT=9.
  - ASCII op-code localparams for the L1 and shared codes.
  - decode functions for 16-bit and 8-bit op codes.
- Sub-module command_fifo: parameterised depth/width, dual write port (ordered), single read port, count output. The top level holds decode, ready logic and counters.

Test Plan:
- Basic decode: reset, cmdReady=1; L1 "DR" addr 0x00001000 for one cycle -> next cycle cmdValid=1, cmdType=0, cmdAddress=0x00001000; readCount=1.
- Ordering: same cycle L1 "DW" 0xA0 and shared "M" 0xB0, FIFO empty -> head cmdType=6/0xB0, then 1/0xA0; writeCount=1, snoopCount=1.
- Backpressure: cmdReady=0, push 4 commands -> l1Ready=sharedReady=0. With count=3 and both valid -> sharedReady=1, l1Ready=0, only the snoop is queued.
- Illegal code: L1 op "XX" -> no cmdValid, errorCount=1, decodeError=1. Then "CL" -> all counters 0, decodeError=0, head cmdType=8.
- Stats and saturation: preload readCount via 0xFFFFFFFF accesses (or force), one more "IR" -> stays 0xFFFFFFFF. Then "PS" -> statsValid high exactly one cycle, FIFO unchanged.
- Reset mid-operation: 3 entries queued, assert reset between edges -> cmdValid drops immediately, counters 0. After release, first new command appears at the head normally.

Source files
------------

// File: rtl/bus_command_pkg.sv
// Shared command encoding and ASCII op-code decode for the bus command receiver.
package bus_command_pkg;

  typedef enum logic [3:0] {
    DATA_READ        = 4'd0,
    DATA_WRITE       = 4'd1,
    INST_READ        = 4'd2,
    SNOOP_INVALIDATE = 4'd3,
    SNOOP_READ       = 4'd4,
    SNOOP_WRITE      = 4'd5,
    SNOOP_RWITM      = 4'd6,
    CLEAR            = 4'd8,
    PRINT            = 4'd9
  } cmd_t;

  localparam int CMD_W = 4;

  localparam logic [15:0] OP_DR = "DR";
  localparam logic [15:0] OP_DW = "DW";
  localparam logic [15:0] OP_IR = "IR";
  localparam logic [15:0] OP_CL = "CL";
  localparam logic [15:0] OP_PR = "PR";
  localparam logic [15:0] OP_PS = "PS";

  localparam logic [7:0] OP_I = "I";
  localparam logic [7:0] OP_R = "R";
  localparam logic [7:0] OP_W = "W";
  localparam logic [7:0] OP_M = "M";

  typedef struct packed {
    logic legal;
    logic stats;
    cmd_t cmd;
  } l1_dec_t;

  typedef struct packed {
    logic legal;
    cmd_t cmd;
  } sh_dec_t;

  function automatic l1_dec_t decode_l1(input logic [15:0] op);
    l1_dec_t d;
    d.legal = 1'b1;
    d.stats = 1'b0;
    d.cmd   = DATA_READ;
    case (op)
      OP_DR:   d.cmd = DATA_READ;
      OP_DW:   d.cmd = DATA_WRITE;
      OP_IR:   d.cmd = INST_READ;
      OP_CL:   d.cmd = CLEAR;
      OP_PR:   d.cmd = PRINT;
      OP_PS:   d.stats = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic sh_dec_t decode_shared(input logic [7:0] op);
    sh_dec_t d;
    d.legal = 1'b1;
    d.cmd   = SNOOP_INVALIDATE;
    case (op)
      OP_I:    d.cmd = SNOOP_INVALIDATE;
      OP_R:    d.cmd = SNOOP_READ;
      OP_W:    d.cmd = SNOOP_WRITE;
      OP_M:    d.cmd = SNOOP_RWITM;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/command_fifo.sv
// Command queue with two ordered write ports (a before b) and a registered head
// that keeps its last value when the queue runs empty.
module command_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_a,
  input  logic [WIDTH-1:0]           data_a,
  input  logic                       push_b,
  input  logic [WIDTH-1:0]           data_b,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_a) begin
      mem_d[wr_ptr_d] = data_a;
      wr_ptr_d        = wr_ptr_d + 1'b1;
      count_d         = count_d + 1'b1;
    end
    if (push_b) begin
      mem_d[wr_ptr_d] = data_b;
      wr_ptr_d        = wr_ptr_d + 1'b1;
      count_d         = count_d + 1'b1;
    end
    if (pop && count_q != '0) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_d - 1'b1;
    end
    // Head is precomputed from next-state so a new entry shows one cycle after its push.
    head_valid_d = (count_d != '0);
    head_d       = head_valid_d ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;
  assign count      = count_q;

endmodule

// File: rtl/bus_command_receiver.sv
// Receives L1 and snoop commands, queues them for the L2 controller and keeps
// saturating per-class statistics published on a print-stats request.
module bus_command_receiver
  import bus_command_pkg::*;
#(
  parameter int addressSize  = 32,
  parameter int fifoDepth    = 4,
  parameter int counterWidth = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [addressSize-1:0]  L1BusIn,
  input  logic [15:0]             L1OperationBusIn,
  input  logic                    l1Valid,
  output logic                    l1Ready,
  input  logic [addressSize-1:0]  sharedBusIn,
  input  logic [7:0]              sharedOperationBusIn,
  input  logic                    sharedValid,
  output logic                    sharedReady,
  output logic                    cmdValid,
  input  logic                    cmdReady,
  output logic [3:0]              cmdType,
  output logic [addressSize-1:0]  cmdAddress,
  output logic [counterWidth-1:0] readCount,
  output logic [counterWidth-1:0] writeCount,
  output logic [counterWidth-1:0] snoopCount,
  output logic [counterWidth-1:0] errorCount,
  output logic                    decodeError,
  output logic                    statsValid
);

  localparam int CNT_W   = $clog2(fifoDepth+1);
  localparam int ENTRY_W = CMD_W + addressSize;

  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               head_valid;
  l1_dec_t            l1_dec;
  sh_dec_t            sh_dec;
  logic               l1_acc, sh_acc, l1_push, sh_push, clear;
  logic               rd_inc, wr_inc, sn_inc;
  logic [1:0]         err_inc;

  logic [counterWidth-1:0] read_cnt_q, read_cnt_d, write_cnt_q, write_cnt_d;
  logic [counterWidth-1:0] snoop_cnt_q, snoop_cnt_d, error_cnt_q, error_cnt_d;
  logic                    decode_error_q, decode_error_d;
  logic                    stats_valid_q, stats_valid_d;

  function automatic logic [counterWidth-1:0] sat_add(input logic [counterWidth-1:0] c,
                                                       input logic [1:0] inc);
    logic [counterWidth:0] s;
    s = {1'b0, c} + {{(counterWidth-1){1'b0}}, inc};
    return s[counterWidth] ? '1 : s[counterWidth-1:0];
  endfunction

  always_comb begin
    l1_dec = decode_l1(L1OperationBusIn);
    sh_dec = decode_shared(sharedOperationBusIn);
  end

  // L1 leaves a slot free for a concurrent snoop; a same-cycle pop never counts.
  assign sharedReady = (count <= CNT_W'(fifoDepth - 1));
  assign l1Ready     = sharedValid ? (count <= CNT_W'(fifoDepth - 2)) : sharedReady;

  assign l1_acc  = l1Valid && l1Ready;
  assign sh_acc  = sharedValid && sharedReady;
  assign l1_push = l1_acc && l1_dec.legal && !l1_dec.stats;
  assign sh_push = sh_acc && sh_dec.legal;
  assign clear   = l1_push && (l1_dec.cmd == CLEAR);
  assign rd_inc  = l1_push && (l1_dec.cmd == DATA_READ || l1_dec.cmd == INST_READ);
  assign wr_inc  = l1_push && (l1_dec.cmd == DATA_WRITE);
  assign sn_inc  = sh_push;
  assign err_inc = {1'b0, l1_acc && !l1_dec.legal} + {1'b0, sh_acc && !sh_dec.legal};

  command_fifo #(.DEPTH(fifoDepth), .WIDTH(ENTRY_W)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_a     (sh_push),
    .data_a     ({sh_dec.cmd, sharedBusIn}),
    .push_b     (l1_push),
    .data_b     ({l1_dec.cmd, L1BusIn}),
    .pop        (head_valid && cmdReady),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_comb begin
    read_cnt_d     = read_cnt_q;
    write_cnt_d    = write_cnt_q;
    snoop_cnt_d    = snoop_cnt_q;
    error_cnt_d    = error_cnt_q;
    decode_error_d = decode_error_q;
    stats_valid_d  = l1_acc && l1_dec.legal && l1_dec.stats;
    // Statistics are frozen while being published; otherwise clear beats any event.
    if (!stats_valid_q) begin
      if (clear) begin
        read_cnt_d     = '0;
        write_cnt_d    = '0;
        snoop_cnt_d    = '0;
        error_cnt_d    = '0;
        decode_error_d = 1'b0;
      end else begin
        read_cnt_d     = sat_add(read_cnt_q, {1'b0, rd_inc});
        write_cnt_d    = sat_add(write_cnt_q, {1'b0, wr_inc});
        snoop_cnt_d    = sat_add(snoop_cnt_q, {1'b0, sn_inc});
        error_cnt_d    = sat_add(error_cnt_q, err_inc);
        decode_error_d = decode_error_q || (err_inc != 2'd0);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_cnt_q     <= '0;
      write_cnt_q    <= '0;
      snoop_cnt_q    <= '0;
      error_cnt_q    <= '0;
      decode_error_q <= 1'b0;
      stats_valid_q  <= 1'b0;
    end else begin
      read_cnt_q     <= read_cnt_d;
      write_cnt_q    <= write_cnt_d;
      snoop_cnt_q    <= snoop_cnt_d;
      error_cnt_q    <= error_cnt_d;
      decode_error_q <= decode_error_d;
      stats_valid_q  <= stats_valid_d;
    end
  end

  assign cmdValid    = head_valid;
  assign cmdType     = head[ENTRY_W-1 -: CMD_W];
  assign cmdAddress  = head[addressSize-1:0];
  assign readCount   = read_cnt_q;
  assign writeCount  = write_cnt_q;
  assign snoopCount  = snoop_cnt_q;
  assign errorCount  = error_cnt_q;
  assign decodeError = decode_error_q;
  assign statsValid  = stats_valid_q;

endmodule

// File: tb/tb_bus_command_receiver.sv
// Scoreboard bench: stimulus pushes expected queue entries, a negedge monitor
// pops and compares them whenever the DUT hands a head to the controller.
module tb_bus_command_receiver;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clock, reset;
  logic [AW-1:0] L1BusIn, sharedBusIn, cmdAddress;
  logic [15:0]   L1OperationBusIn;
  logic [7:0]    sharedOperationBusIn;
  logic          l1Valid, l1Ready, sharedValid, sharedReady;
  logic          cmdValid, cmdReady, decodeError, statsValid;
  logic [3:0]    cmdType;
  logic [CW-1:0] readCount, writeCount, snoopCount, errorCount;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0]    t;
    logic [AW-1:0] a;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  bus_command_receiver #(.addressSize(AW), .fifoDepth(DEPTH), .counterWidth(CW)) dut (
    .clock                (clock),
    .reset                (reset),
    .L1BusIn              (L1BusIn),
    .L1OperationBusIn     (L1OperationBusIn),
    .l1Valid              (l1Valid),
    .l1Ready              (l1Ready),
    .sharedBusIn          (sharedBusIn),
    .sharedOperationBusIn (sharedOperationBusIn),
    .sharedValid          (sharedValid),
    .sharedReady          (sharedReady),
    .cmdValid             (cmdValid),
    .cmdReady             (cmdReady),
    .cmdType              (cmdType),
    .cmdAddress           (cmdAddress),
    .readCount            (readCount),
    .writeCount           (writeCount),
    .snoopCount           (snoopCount),
    .errorCount           (errorCount),
    .decodeError          (decodeError),
    .statsValid           (statsValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a head visible with cmdReady high at the negedge is consumed next edge.
  always @(negedge clock) begin
    if (!reset && cmdValid && cmdReady) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL head_unexpected: got type %0d addr 0x%0h, expected no entry",
                 cmdType, cmdAddress);
      end else begin
        e = exp_q.pop_front();
        chk("head", 64'({cmdType, cmdAddress}), 64'({e.t, e.a}));
      end
    end
  end

  // Called at posedge+1; drives one cycle, checks readies, returns at posedge+1.
  task automatic send(input logic l1v, input logic [15:0] l1op, input logic [AW-1:0] l1a,
                      input int l1exp, input logic shv, input logic [7:0] shop,
                      input logic [AW-1:0] sha, input int shexp,
                      input logic exp_l1r, input logic exp_shr);
    l1Valid              = l1v;
    L1OperationBusIn     = l1op;
    L1BusIn              = l1a;
    sharedValid          = shv;
    sharedOperationBusIn = shop;
    sharedBusIn          = sha;
    @(negedge clock);
    if (l1v) chk("l1Ready", 64'(l1Ready), 64'(exp_l1r));
    if (shv) chk("sharedReady", 64'(sharedReady), 64'(exp_shr));
    if (shv && exp_shr && shexp >= 0) exp_q.push_back('{t: 4'(shexp), a: sha});
    if (l1v && exp_l1r && l1exp >= 0) exp_q.push_back('{t: 4'(l1exp), a: l1a});
    @(posedge clock);
    #1;
    l1Valid     = 1'b0;
    sharedValid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries never reached the head", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    l1Valid = 1'b0; sharedValid = 1'b0; cmdReady = 1'b0;
    L1BusIn = '0; sharedBusIn = '0; L1OperationBusIn = '0; sharedOperationBusIn = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cmdValid", 64'(cmdValid), 64'd0);
    chk("rst_cmdType", 64'(cmdType), 64'd0);
    chk("rst_cmdAddress", 64'(cmdAddress), 64'd0);
    chk("rst_counts", 64'({readCount, writeCount, snoopCount, errorCount}), 64'd0);
    chk("rst_flags", 64'({decodeError, statsValid}), 64'd0);
    chk("rst_readies", 64'({l1Ready, sharedReady}), 64'b11);
    reset = 1'b0;
    cmdReady = 1'b1;

    // Basic decode and one-cycle latency; empty head holds its last value.
    send(1, "DR", 32'h0000_1000, 0, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("dr_cmdValid", 64'(cmdValid), 64'd1);
    chk("dr_readCount", 64'(readCount), 64'd1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("empty_cmdValid", 64'(cmdValid), 64'd0);
    chk("empty_hold_addr", 64'(cmdAddress), 64'h0000_1000);
    @(posedge clock); #1;

    // Same-cycle snoop and L1: snoop first.
    send(1, "DW", 32'h0000_00A0, 1, 1, "M", 32'h0000_00B0, 6, 1, 1);
    drain();
    chk("ord_writeCount", 64'(writeCount), 64'd1);
    chk("ord_snoopCount", 64'(snoopCount), 64'd1);

    // Backpressure: fill to depth with the consumer stalled.
    cmdReady = 1'b0;
    send(1, "DR", 32'h10, 0, 0, 8'h00, '0, -1, 1, 1);
    send(1, "DW", 32'h20, 1, 0, 8'h00, '0, -1, 1, 1);
    send(1, "IR", 32'h30, 2, 0, 8'h00, '0, -1, 1, 1);
    send(1, "PR", 32'h40, 9, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("full_readies", 64'({l1Ready, sharedReady}), 64'b00);
    chk("full_head_stable", 64'({cmdValid, cmdType, cmdAddress}), 64'({1'b1, 4'd0, 32'h10}));
    @(posedge clock); #1;
    send(1, "DR", 32'h50, 0, 1, "R", 32'h60, 4, 0, 0);
    cmdReady = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    cmdReady = 1'b0;
    send(1, "DW", 32'h70, 1, 1, "W", 32'h80, 5, 0, 1);
    cmdReady = 1'b1;
    @(negedge clock);
    chk("pop_no_ready_raise", 64'(l1Ready), 64'd0);
    @(posedge clock); #1;
    drain();
    chk("bp_counts", 64'({readCount, writeCount, snoopCount}), 64'({4'd3, 4'd2, 4'd2}));

    // Illegal codes on both channels, then CL clears with a same-cycle snoop discarded.
    send(1, "XX", 32'h99, -1, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("ill_cmdValid", 64'(cmdValid), 64'd0);
    chk("ill_err", 64'({errorCount, decodeError}), 64'({4'd1, 1'b1}));
    @(posedge clock); #1;
    send(0, 16'h0000, '0, -1, 1, "Z", 32'h77, -1, 1, 1);
    @(negedge clock);
    chk("ill_sh_errorCount", 64'(errorCount), 64'd2);
    @(posedge clock); #1;
    send(1, "CL", 32'h123, 8, 1, "I", 32'h55, 3, 1, 1);
    @(negedge clock);
    chk("cl_counts", 64'({readCount, writeCount, snoopCount, errorCount}), 64'd0);
    chk("cl_decodeError", 64'(decodeError), 64'd0);
    @(posedge clock); #1;
    drain();

    // Saturation at all-ones.
    for (int i = 0; i < 15; i++)
      send(1, "IR", 32'(32'h1000 + i), 2, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("sat_reach", 64'(readCount), 64'hF);
    @(posedge clock); #1;
    send(1, "IR", 32'h2000, 2, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("sat_hold", 64'(readCount), 64'hF);
    @(posedge clock); #1;
    drain();

    // Print stats: one-cycle pulse, nothing queued, counters frozen in that cycle.
    cmdReady = 1'b0;
    send(1, "PS", 32'hEE, -1, 0, 8'h00, '0, -1, 1, 1);
    l1Valid = 1'b1; L1OperationBusIn = "DW"; L1BusIn = 32'hD0;
    exp_q.push_back('{t: 4'd1, a: 32'hD0});
    @(negedge clock);
    chk("ps_pulse", 64'({statsValid, cmdValid}), 64'b10);
    @(posedge clock); #1;
    l1Valid = 1'b0;
    @(negedge clock);
    chk("ps_pulse_end", 64'(statsValid), 64'd0);
    chk("ps_frozen_write", 64'(writeCount), 64'd0);
    chk("ps_dw_queued", 64'({cmdValid, cmdType}), 64'({1'b1, 4'd1}));
    @(posedge clock); #1;
    cmdReady = 1'b1;
    drain();

    // Asynchronous reset with entries queued.
    cmdReady = 1'b0;
    send(1, "DR", 32'h100, 0, 0, 8'h00, '0, -1, 1, 1);
    send(1, "DW", 32'h200, 1, 0, 8'h00, '0, -1, 1, 1);
    send(0, 16'h0000, '0, -1, 1, "R", 32'h300, 4, 1, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_cmdValid", 64'(cmdValid), 64'd0);
    chk("arst_counts", 64'({readCount, writeCount, snoopCount, errorCount}), 64'd0);
    chk("arst_head", 64'({cmdType, cmdAddress}), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    cmdReady = 1'b1;
    send(1, "IR", 32'h400, 2, 0, 8'h00, '0, -1, 1, 1);
    @(negedge clock);
    chk("post_rst_readCount", 64'(readCount), 64'd1);
    @(posedge clock); #1;
    drain();
    @(negedge clock);
    chk("end_empty", 64'(cmdValid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
